chu_rotary_enc_multi: RTL and testbench

MMIO slot core that decodes up to 8 Pmod quadrature rotary encoders, each with a push switch, into signed position counters readable by the MicroBlaze MCS over the FPro bus. It generalises single-encoder handling to N channels, with selectable x1/x2/x4 resolution, per-channel direction inversion, wrap or saturate arithmetic, counter preset, and sticky change, press and error flags. It plugs into one slot of the mmio subsystem, with encoder pins routed from the Pmod header.

---
 rtl/chu_rotary_enc_multi_if.sv | 11 +
 rtl/chu_rotary_enc_multi.sv | 139 +++++++++++++
 tb/tb_chu_rotary_enc_multi.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/chu_rotary_enc_multi_if.sv
// chu_rotary_enc_multi_if: FPro slot bus between the MCS bridge and the encoder core
interface chu_rotary_enc_multi_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_rotary_enc_multi.sv
// chu_rotary_enc_multi: N-channel filtered quadrature decoder with MMIO counters and sticky flags
module chu_rotary_enc_multi #(
  parameter int N_CH   = 2,
  parameter int W      = 16,
  parameter int FILT_N = 16
) (
  input  logic                clk,
  input  logic                reset,
  chu_rotary_enc_multi_if.slave bus,
  input  logic [N_CH-1:0]     enc_a,
  input  logic [N_CH-1:0]     enc_b,
  input  logic [N_CH-1:0]     enc_sw
);
  localparam int P  = 3 * N_CH;
  localparam int CW = $clog2(FILT_N + 1);
  localparam logic [CW-1:0] LAST = CW'(FILT_N - 1);
  localparam logic [W-1:0]  MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN  = {1'b1, {(W-1){1'b0}}};
  logic [P-1:0]    s1_q, s1_d, s2_q, s2_d, filt_q, filt_d, vld_q, vld_d;
  logic [CW-1:0]   run_q [P];
  logic [CW-1:0]   run_d [P];
  logic [1:0]      fill_q, fill_d;
  logic [W-1:0]    cnt_q [N_CH];
  logic [W-1:0]    cnt_d [N_CH];
  logic [1:0]      prev_q [N_CH];
  logic [1:0]      prev_d [N_CH];
  logic [N_CH-1:0] prime_q, prime_d, chg_q, chg_d, prs_q, prs_d, err_q, err_d;
  logic [N_CH-1:0] sw_q, sw_d, inv_q, inv_d;
  logic [1:0]      mode_q, mode_d;
  logic            sat_q, sat_d;
  logic            wr;
  logic [31:0]     rd;
  logic            unused;
  function automatic logic [1:0] g2b(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction
  assign wr = bus.cs & bus.write;
  assign unused = &{1'b0, bus.read, bus.wr_data, vld_q};
  // fill_q holds off the filters until the synchroniser carries real samples after reset
  always_comb begin
    s1_d   = {enc_sw, enc_b, enc_a};
    s2_d   = s1_q;
    fill_d = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    filt_d = filt_q;
    vld_d  = vld_q;
    for (int p = 0; p < P; p++) begin
      run_d[p] = (fill_q != 2'd2 || s1_q[p] != s2_q[p]) ? '0 :
                 (run_q[p] == LAST) ? run_q[p] : run_q[p] + CW'(1);
      if (fill_q == 2'd2 && s1_q[p] == s2_q[p] && run_q[p] == LAST) begin
        filt_d[p] = s2_q[p];
        vld_d[p]  = 1'b1;
      end
    end
  end
  always_comb begin
    sw_d    = filt_q[2*N_CH +: N_CH];
    chg_d   = chg_q;
    prs_d   = prs_q;
    err_d   = err_q;
    inv_d   = inv_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    prime_d = prime_q;
    if (wr && bus.addr == 5'd9) begin
      chg_d = chg_d & ~bus.wr_data[N_CH-1:0];
      prs_d = prs_d & ~bus.wr_data[16 +: N_CH];
      err_d = err_d & ~bus.wr_data[24 +: N_CH];
    end
    if (wr && bus.addr == 5'd10) begin
      inv_d  = bus.wr_data[N_CH-1:0];
      mode_d = bus.wr_data[9:8];
      sat_d  = bus.wr_data[10];
    end
    prs_d = prs_d | (sw_d & ~sw_q);
    for (int i = 0; i < N_CH; i++) begin
      logic [1:0] cur, dlt;
      logic en, up, clamp, pre, step, rdy;
      cur        = {filt_q[i], filt_q[N_CH+i]};
      dlt        = g2b(cur) - g2b(prev_q[i]);
      en         = mode_q[1] | (mode_q[0] ? cur[1] ^ prev_q[i][1] : cur[1] & ~prev_q[i][1]);
      up         = (dlt == 2'd1) ^ inv_q[i];
      clamp      = sat_q & (up ? cnt_q[i] == MAX : cnt_q[i] == MIN);
      pre        = wr && bus.addr == 5'(i);
      rdy        = vld_q[i] & vld_q[N_CH+i];
      step       = prime_q[i] && dlt[0] && en && !clamp && !pre;
      prime_d[i] = prime_q[i] | rdy;
      prev_d[i]  = (prime_q[i] | rdy) ? cur : prev_q[i];
      err_d[i]   = err_d[i] | (prime_q[i] && dlt == 2'd2);
      chg_d[i]   = chg_d[i] | step;
      cnt_d[i]   = pre ? bus.wr_data[W-1:0] :
                   step ? (up ? cnt_q[i] + W'(1) : cnt_q[i] - W'(1)) : cnt_q[i];
    end
  end
  always_comb begin
    rd = '0;
    for (int i = 0; i < N_CH; i++)
      if (bus.addr == 5'(i)) rd = 32'($signed(cnt_q[i]));
    if (bus.addr == 5'd8)  rd = {8'(err_q), 8'(prs_q), 8'(sw_q), 8'(chg_q)};
    if (bus.addr == 5'd10) rd = {21'd0, sat_q, mode_q, 8'(inv_q)};
  end
  assign bus.rd_data = rd;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      filt_q  <= '0;
      vld_q   <= '0;
      fill_q  <= '0;
      run_q   <= '{default: '0};
      cnt_q   <= '{default: '0};
      prev_q  <= '{default: '0};
      prime_q <= '0;
      chg_q   <= '0;
      prs_q   <= '0;
      err_q   <= '0;
      sw_q    <= '0;
      inv_q   <= '0;
      mode_q  <= 2'b10;
      sat_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      filt_q  <= filt_d;
      vld_q   <= vld_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
      chg_q   <= chg_d;
      prs_q   <= prs_d;
      err_q   <= err_d;
      sw_q    <= sw_d;
      inv_q   <= inv_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
    end
  end
endmodule

// File: tb/tb_chu_rotary_enc_multi.sv
// tb_chu_rotary_enc_multi: register table, directed encoder sequences and randomized model check
module tb_chu_rotary_enc_multi;
  localparam int N_CH = 2, W = 16, FILT_N = 4, H = FILT_N + 8, SETTLE = FILT_N + 6;
  localparam int MAXV = 2 ** (W - 1) - 1, MINV = -(2 ** (W - 1));
  logic clk = 1'b0, reset = 1'b1;
  logic [N_CH-1:0] enc_a, enc_b, enc_sw;
  int n_cmp = 0, n_bad = 0;
  int ph [N_CH];
  int mc [N_CH];
  logic [N_CH-1:0] mchg, merr, minv;
  logic [1:0] mmode;
  bit msat;
  typedef struct { bit w; logic [4:0] a; logic [31:0] d; logic [31:0] e; } vec_t;
  vec_t tbl [19];
  chu_rotary_enc_multi_if bus ();
  chu_rotary_enc_multi #(.N_CH(N_CH), .W(W), .FILT_N(FILT_N)) dut (
    .clk(clk), .reset(reset), .bus(bus), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1; bus.read = 1; bus.addr = a;
    #1 d = bus.rd_data;
    bus.cs = 0; bus.read = 0;
  endtask
  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] e);
    logic [31:0] d;
    rd(a, d);
    check(nm, d, e);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1; bus.write = 1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 0; bus.write = 0;
  endtask
  task automatic drive(input int ch, input int np);
    ph[ch] = np;
    enc_a[ch] = (np == 2 || np == 3);
    enc_b[ch] = (np == 1 || np == 2);
  endtask
  task automatic go(input int ch, input int np);
    @(negedge clk);
    drive(ch, np);
    repeat (H) @(negedge clk);
  endtask
  task automatic walk(input int ch, input int n, input int dir);
    for (int k = 0; k < n; k++) go(ch, (ph[ch] + dir + 4) % 4);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (SETTLE) @(negedge clk);
  endtask
  // reference: Gray index 0..3 = ab 00,01,11,10; a = idx 2/3, b = idx 1/2
  task automatic mstep(input int ch, input int np);
    int old, diff, d, nv;
    bit fwd;
    old  = ph[ch];
    diff = (np - old + 4) % 4;
    fwd  = (diff == 1);
    d    = 0;
    if (diff == 2) merr[ch] = 1;
    else if (diff != 0) begin
      if (mmode[1]) d = fwd ? 1 : -1;
      else if (mmode[0]) d = ((old >= 2) != (np >= 2)) ? (fwd ? 1 : -1) : 0;
      else d = (old < 2 && np >= 2) ? ((np == 1 || np == 2) ? 1 : -1) : 0;
      if (minv[ch]) d = -d;
      if (d != 0) begin
        nv = mc[ch] + d;
        if (msat) begin
          if (nv <= MAXV && nv >= MINV) begin mc[ch] = nv; mchg[ch] = 1; end
        end else begin
          mc[ch] = nv > MAXV ? nv - 2 ** W : nv < MINV ? nv + 2 ** W : nv;
          mchg[ch] = 1;
        end
      end
    end
    go(ch, np);
  endtask
  initial begin
    logic [31:0] d;
    logic [15:0] val;
    logic [1:0] m;
    logic [N_CH-1:0] iv;
    int lat, r, ch;
    bit sb;
    bus.cs = 0; bus.read = 0; bus.write = 0; bus.addr = '0; bus.wr_data = '0;
    enc_sw = '0;
    for (int i = 0; i < N_CH; i++) drive(i, 2);
    tbl = '{
      '{0, 5'd10, 0, 32'h200}, '{0, 5'd8, 0, 0}, '{0, 5'd0, 0, 0}, '{0, 5'd1, 0, 0},
      '{0, 5'd9, 0, 0}, '{0, 5'd2, 0, 0}, '{0, 5'd11, 0, 0},
      '{1, 5'd1, 32'h0001ABCD, 0}, '{0, 5'd1, 0, 32'hFFFFABCD},
      '{1, 5'd10, 32'hFFFFFFFF, 0}, '{0, 5'd10, 0, 32'h703},
      '{1, 5'd10, 32'h200, 0}, '{0, 5'd10, 0, 32'h200},
      '{1, 5'd5, 32'h1234, 0}, '{0, 5'd5, 0, 0},
      '{1, 5'd1, 32'h0, 0}, '{0, 5'd1, 0, 0},
      '{1, 5'd8, 32'hFFFFFFFF, 0}, '{0, 5'd8, 0, 0}
    };
    do_reset();
    rd_chk("prime_count0", 0, 0);
    rd_chk("prime_status", 8, 0);
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
      else rd_chk($sformatf("tbl%0d_addr%0d", i, tbl[i].a), tbl[i].a, tbl[i].e);
    end
    walk(0, 8, 1);
    rd_chk("x4_fwd8", 0, 8);
    rd_chk("x4_chg", 8, 32'h1);
    walk(0, 3, -1);
    rd_chk("x4_rev3", 0, 5);
    wr(9, 32'h01);
    rd_chk("clear_chg", 8, 0);
    wr(10, 32'h001);
    walk(0, 4, 1);
    rd_chk("x1_inv", 0, 4);
    wr(10, 32'h101);
    walk(0, 4, 1);
    rd_chk("x2_inv", 0, 2);
    wr(10, 32'h100);
    walk(0, 4, 1);
    rd_chk("x2_fwd", 0, 4);
    wr(10, 32'h200);
    wr(0, 32'h7FFF);
    walk(0, 1, 1);
    rd_chk("wrap", 0, 32'hFFFF8000);
    wr(9, 32'hFFFFFFFF);
    wr(10, 32'h600);
    wr(0, 32'h7FFF);
    walk(0, 1, 1);
    rd_chk("sat_count", 0, 32'h7FFF);
    rd_chk("sat_nochg", 8, 0);
    wr(10, 32'h200);
    @(negedge clk);
    enc_a[0] = ~enc_a[0];
    repeat (FILT_N - 1) @(negedge clk);
    enc_a[0] = ~enc_a[0];
    repeat (H) @(negedge clk);
    rd_chk("glitch_count", 0, 32'h7FFF);
    rd_chk("glitch_status", 8, 0);
    go(0, (ph[0] + 2) % 4);
    rd_chk("illegal_count", 0, 32'h7FFF);
    rd_chk("illegal_err", 8, 32'h01000000);
    // preset held across the whole window in which the ch1 step can land
    @(negedge clk);
    drive(1, 3);
    bus.cs = 1; bus.write = 1; bus.addr = 1; bus.wr_data = 100;
    repeat (FILT_N + 8) @(negedge clk);
    bus.cs = 0; bus.write = 0;
    repeat (H) @(negedge clk);
    rd_chk("preset_wins", 1, 100);
    rd_chk("preset_nochg", 8, 32'h01000000);
    @(negedge clk);
    enc_sw[1] = 1;
    lat = 0;
    for (int t = 1; t <= 40 && lat == 0; t++) begin
      rd(8, d);
      if (d[17]) lat = t;
    end
    n_cmp++;
    if (lat == 0) begin n_bad++; $display("FAIL press_timeout: got no PRS expected PRS[1] within 40 cycles"); lat = 1; end
    rd_chk("press", 8, 32'h01020200);
    @(negedge clk);
    enc_sw[1] = 0;
    repeat (H) @(negedge clk);
    wr(9, 32'h020000);
    rd_chk("press_clear", 8, 32'h01000000);
    @(negedge clk);
    enc_sw[1] = 1;
    repeat (lat - 1) @(negedge clk);
    bus.cs = 1; bus.write = 1; bus.addr = 9; bus.wr_data = 32'h020000;
    @(negedge clk);
    bus.cs = 0; bus.write = 0;
    repeat (H) @(negedge clk);
    rd_chk("set_beats_clear", 8, 32'h01020200);
    enc_sw = '0;
    for (int i = 0; i < N_CH; i++) drive(i, 2);
    do_reset();
    mc = '{default: 0};
    mchg = '0; merr = '0; minv = '0; mmode = 2'b10; msat = 0;
    for (int it = 0; it < 70; it++) begin
      r  = $urandom_range(0, 11);
      ch = $urandom_range(0, N_CH - 1);
      if (r == 0) begin
        m = 2'($urandom_range(0, 3)); iv = N_CH'($urandom_range(0, 3)); sb = 1'($urandom_range(0, 1));
        wr(10, {21'd0, sb, m, 6'd0, iv});
        mmode = m; minv = iv; msat = sb;
      end else if (r == 1) begin
        case ($urandom_range(0, 6))
          0: val = 16'h7FFF; 1: val = 16'h8000; 2: val = 16'h7FFE; 3: val = 16'h8001;
          4: val = 16'h0000; 5: val = 16'hFFFF; default: val = 16'($urandom);
        endcase
        wr(5'(ch), {16'($urandom), val});
        mc[ch] = int'($signed(val));
      end else if (r == 2) begin
        wr(9, 32'hFFFFFFFF);
        mchg = '0; merr = '0;
      end else if (r == 3) mstep(ch, (ph[ch] + 2) % 4);
      else mstep(ch, (ph[ch] + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4);
      rd_chk($sformatf("rand%0d_count%0d", it, ch), 5'(ch), 32'(mc[ch]));
      rd_chk($sformatf("rand%0d_status", it), 8, {8'(merr), 16'd0, 8'(mchg)});
    end
    @(negedge clk);
    drive(0, (ph[0] + 1) % 4);
    repeat (2) @(negedge clk);
    do_reset();
    repeat (H) @(negedge clk);
    rd_chk("midreset_count", 0, 0);
    rd_chk("midreset_status", 8, 0);
    walk(0, 1, 1);
    rd_chk("reprime_step", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
